// File: rtl/bwop_pkg.sv
// Shared types and the pure bitwise function for the bwop_unit slice.
// Operand width is carried by BWOP_MAX_WIDTH; callers zero-extend and slice.
package bwop_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_PASS_A = 3'd6,
        OP_NOT_A  = 3'd7
    } op_e;

    localparam int BWOP_MAX_WIDTH = 64;

    typedef logic [BWOP_MAX_WIDTH-1:0] word_t;

    function automatic word_t bwop_calc(input op_e op, input word_t a, input word_t b);
        word_t r;
        r = '0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_PASS_A: r = a;
            OP_NOT_A:  r = ~a;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bwop_if.sv
// Handshake bundle for bwop_unit; DUT_mp faces the block, TB_mp faces its driver.
// The parity signal exists only when BWOP_PARITY_EN is defined.
interface bwop_if #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst_n
);
    import bwop_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [15:0]      txn_count;
`ifdef BWOP_PARITY_EN
    logic             parity;
`endif

    modport DUT_mp (
        input  clk, rst_n, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, txn_count
`ifdef BWOP_PARITY_EN
        , output parity
`endif
    );

    modport TB_mp (
        output in_valid, op, a, b, out_ready,
        input  clk, rst_n, in_ready, out_valid, y, zero, txn_count
`ifdef BWOP_PARITY_EN
        , input parity
`endif
    );

endinterface

// File: rtl/bwop_fifo.sv
// Generic DEPTH x DW synchronous FIFO with count-based full/empty and a
// combinational head read; pushes when full and pops when empty are ignored.
module bwop_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is reset too, so the head reads zero straight out of reset
    // rather than X; all sequential state uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/bwop_unit.sv
// Registered bitwise-operation unit: valid/ready request in, FIFO-buffered
// result out. Define BWOP_PARITY_EN to store and expose a per-result parity bit.
module bwop_unit import bwop_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
`ifdef BWOP_PARITY_EN
    output logic             parity,
`endif
    output logic [15:0]      txn_count
);
`ifdef BWOP_PARITY_EN
    localparam int PW = WIDTH + 2;
`else
    localparam int PW = WIDTH + 1;
`endif

    word_t            calc_full;
    logic [WIDTH-1:0] calc_y;
    logic [PW-1:0]    push_data;
    logic [PW-1:0]    head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign calc_full = bwop_calc(op, word_t'(a), word_t'(b));
    assign calc_y    = calc_full[WIDTH-1:0];

    // Upper bits of the wide function result are intentionally discarded.
    if (WIDTH < BWOP_MAX_WIDTH) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^calc_full[BWOP_MAX_WIDTH-1:WIDTH];
    end

`ifdef BWOP_PARITY_EN
    assign push_data = {^calc_y, ~|calc_y, calc_y};
    assign parity    = head[WIDTH+1];
`else
    assign push_data = {~|calc_y, calc_y};
`endif

    assign y         = head[WIDTH-1:0];
    assign zero      = head[WIDTH];
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    bwop_fifo #(
        .DEPTH (DEPTH),
        .DW    (PW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (push) begin
            txn_count <= txn_count + 16'd1;
        end
    end

endmodule
